// File: rtl/quadram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : quadram_arbiter
//  Purpose  : Two-requester arbiter for one quadram port (byte-lane write
//             enables, synchronous read, 1-cycle read latency). Requester 0
//             is the host/SPI load-unload path, requester 1 is the subsurf
//             engine. Round-robin between the two, with a burst lock that
//             lets the current owner keep the port. A locked owner is forced
//             to rotate after MAX_BURST grants if the other side is waiting.
//  Ports    : clk, rstb (async, active low)
//             rX_req/lock/we/addr/wdata in; rX_gnt (combinational),
//             rX_rvalid/rX_rdata read return; ram_en/we/addr/din out,
//             ram_dout in; owner = side granted last.
//  Options  : `define QUADRAM_ARB_STATS_EN adds r0_stall_cnt/r1_stall_cnt,
//             16-bit saturating counts of requested-but-not-granted cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module quadram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rstb,
    input  logic                    r0_req,
    input  logic                    r0_lock,
    input  logic [DATA_WIDTH/8-1:0] r0_we,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    output logic                    r0_gnt,
    output logic                    r0_rvalid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    input  logic                    r1_req,
    input  logic                    r1_lock,
    input  logic [DATA_WIDTH/8-1:0] r1_we,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    output logic                    r1_gnt,
    output logic                    r1_rvalid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    ram_en,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
`ifdef QUADRAM_ARB_STATS_EN
    output logic [15:0]             r0_stall_cnt,
    output logic [15:0]             r1_stall_cnt,
`endif
    output logic                    owner
);

    localparam int c_BE_WIDTH  = DATA_WIDTH / 8;
    localparam int c_CNT_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_CNT_WIDTH-1:0] c_BURST_LAST = c_CNT_WIDTH'(MAX_BURST - 1);

    logic                   r_owner;
    logic                   r_lock_held;
    logic [c_CNT_WIDTH-1:0] r_burst_cnt;
    logic                   r_rvalid0;
    logic                   r_rvalid1;
    logic [DATA_WIDTH-1:0]  r_rdata_hold0;
    logic [DATA_WIDTH-1:0]  r_rdata_hold1;

    logic                   w_holder_req;
    logic                   w_other_req;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_any;
    logic                   w_win;
    logic                   w_win_lock;

    // While locked, r_owner is the lock holder.
    assign w_holder_req = r_owner ? r1_req : r0_req;
    assign w_other_req  = r_owner ? r0_req : r1_req;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_lock_held && w_holder_req) begin
            // Holder keeps the port unless its burst is exhausted and the
            // other side is waiting.
            if ((r_burst_cnt == c_BURST_LAST) && w_other_req) begin
                w_gnt0 = r_owner;
                w_gnt1 = !r_owner;
            end else begin
                w_gnt0 = !r_owner;
                w_gnt1 = r_owner;
            end
        end else if (r0_req && !r1_req) begin
            w_gnt0 = 1'b1;
        end else if (r1_req && !r0_req) begin
            w_gnt1 = 1'b1;
        end else if (r0_req && r1_req) begin
            w_gnt0 = r_owner;
            w_gnt1 = !r_owner;
        end
    end

    assign w_any      = w_gnt0 | w_gnt1;
    assign w_win      = w_gnt1;
    assign w_win_lock = w_gnt1 ? r1_lock : (w_gnt0 & r0_lock);

    always_comb begin
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_gnt0) begin
            ram_we   = r0_we;
            ram_addr = r0_addr;
            ram_din  = r0_wdata;
        end else if (w_gnt1) begin
            ram_we   = r1_we;
            ram_addr = r1_addr;
            ram_din  = r1_wdata;
        end
    end

    assign ram_en = w_any;
    assign r0_gnt = w_gnt0;
    assign r1_gnt = w_gnt1;
    assign owner  = r_owner;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_owner       <= 1'b1;
            r_lock_held   <= 1'b0;
            r_burst_cnt   <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata_hold0 <= '0;
            r_rdata_hold1 <= '0;
        end else begin
            if (w_any) begin
                r_owner     <= w_win;
                r_lock_held <= w_win_lock;
                if ((w_win != r_owner) || !w_win_lock) begin
                    r_burst_cnt <= '0;
                end else if (r_burst_cnt != c_BURST_LAST) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else begin
                r_lock_held <= 1'b0;
                r_burst_cnt <= '0;
            end
            r_rvalid0 <= w_gnt0 && (r0_we == {c_BE_WIDTH{1'b0}});
            r_rvalid1 <= w_gnt1 && (r1_we == {c_BE_WIDTH{1'b0}});
            if (r_rvalid0) begin
                r_rdata_hold0 <= ram_dout;
            end
            if (r_rvalid1) begin
                r_rdata_hold1 <= ram_dout;
            end
        end
    end

    // The quadram presents read data in the cycle after the address, which
    // is exactly the rvalid cycle, so rdata passes ram_dout straight through
    // while valid and otherwise shows the last value returned.
    assign r0_rdata = r_rvalid0 ? ram_dout : r_rdata_hold0;
    assign r1_rdata = r_rvalid1 ? ram_dout : r_rdata_hold1;
    assign r0_rvalid = r_rvalid0;
    assign r1_rvalid = r_rvalid1;

`ifdef QUADRAM_ARB_STATS_EN
    logic [15:0] r_stall0;
    logic [15:0] r_stall1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stall0 <= '0;
            r_stall1 <= '0;
        end else begin
            if (r0_req && !w_gnt0 && (r_stall0 != 16'hFFFF)) begin
                r_stall0 <= r_stall0 + 16'd1;
            end
            if (r1_req && !w_gnt1 && (r_stall1 != 16'hFFFF)) begin
                r_stall1 <= r_stall1 + 16'd1;
            end
        end
    end

    assign r0_stall_cnt = r_stall0;
    assign r1_stall_cnt = r_stall1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quadram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quadram_arbiter
//  Purpose  : Self-checking bench for quadram_arbiter with a 16-word
//             quadram model and a rule-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quadram_arbiter;

    localparam int MAX_BURST = 16;

    logic        clk;
    logic        rstb;
    logic        r0_req, r0_lock, r1_req, r1_lock;
    logic [3:0]  r0_we, r1_we;
    logic [10:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        owner;
`ifdef QUADRAM_ARB_STATS_EN
    logic [15:0] r0_stall_cnt, r1_stall_cnt;
`endif

    quadram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstb(rstb),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout),
`ifdef QUADRAM_ARB_STATS_EN
        .r0_stall_cnt(r0_stall_cnt), .r1_stall_cnt(r1_stall_cnt),
`endif
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quadram model: byte-lane writes, registered read (read-first).
    logic        mem_clear;
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            ram_dout <= 32'h0;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_din[8*b +: 8];
            ram_dout <= mem[ram_addr[3:0]];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (spec rules) ----------------
    bit          m_owner, m_lock, m_rv0, m_rv1;
    int          m_burst, m_st0, m_st1;
    logic [31:0] m_rd0, m_rd1;
    logic [31:0] shadow [0:15];

    task automatic model_reset();
        m_owner = 1'b1; m_lock = 1'b0; m_burst = 0;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 32'h0; m_rd1 = 32'h0;
        m_st0 = 0; m_st1 = 0;
    endtask

    // Returns -1 for no grant, else the winning requester.
    function automatic int model_winner();
        int h = m_owner ? 1 : 0;
        bit hreq = h ? r1_req : r0_req;
        bit oreq = h ? r0_req : r1_req;
        if (m_lock && hreq) begin
            if (m_burst == MAX_BURST - 1 && oreq) return 1 - h;
            return h;
        end
        if (r0_req && !r1_req) return 0;
        if (r1_req && !r0_req) return 1;
        if (r0_req && r1_req)  return 1 - h;
        return -1;
    endfunction

    task automatic model_step(input int w);
        logic [3:0]  we;
        logic [3:0]  a;
        logic [31:0] d;
        bit          lk;
        if (r0_req && w != 0 && m_st0 < 65535) m_st0++;
        if (r1_req && w != 1 && m_st1 < 65535) m_st1++;
        m_rv0 = 1'b0; m_rv1 = 1'b0;
        if (w < 0) begin
            m_lock = 1'b0; m_burst = 0;
            return;
        end
        we = (w == 1) ? r1_we : r0_we;
        a  = (w == 1) ? r1_addr[3:0] : r0_addr[3:0];
        d  = (w == 1) ? r1_wdata : r0_wdata;
        lk = (w == 1) ? r1_lock : r0_lock;
        if (w != int'(m_owner) || !lk) m_burst = 0;
        else if (m_burst < MAX_BURST - 1) m_burst++;
        m_owner = (w == 1);
        m_lock  = lk;
        if (we == 4'h0) begin
            if (w == 0) begin m_rv0 = 1'b1; m_rd0 = shadow[a]; end
            else        begin m_rv1 = 1'b1; m_rd1 = shadow[a]; end
        end else begin
            for (int b = 0; b < 4; b++)
                if (we[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic check_all();
        int w = model_winner();
        logic [47:0] exp_ram;
        exp_ram = 48'h0;
        if (w == 0) exp_ram = {1'b1, r0_we, r0_addr, r0_wdata};
        if (w == 1) exp_ram = {1'b1, r1_we, r1_addr, r1_wdata};
        check("gnt", {r0_gnt, r1_gnt}, {w == 0, w == 1});
        check("owner_rvalid", {owner, r0_rvalid, r1_rvalid}, {m_owner, m_rv0, m_rv1});
        check("ram_bus", {ram_en, ram_we, ram_addr, ram_din}, exp_ram);
        check("rdata", {r0_rdata, r1_rdata}, {m_rd0, m_rd1});
`ifdef QUADRAM_ARB_STATS_EN
        check("stall", {r0_stall_cnt, r1_stall_cnt}, {m_st0[15:0], m_st1[15:0]});
`endif
    endtask

    // Inputs are driven 1 time unit after the rising edge; mid() moves to the
    // falling edge for sampling, tick() crosses the next rising edge.
    task automatic mid();
        #4;
    endtask

    task automatic tick();
        int w = model_winner();
        @(posedge clk);
        model_step(w);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_lock = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_lock = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstb = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        bit          q0, k0; logic [3:0] we0; logic [10:0] a0; logic [31:0] d0;
        bit          q1, k1; logic [3:0] we1; logic [10:0] a1; logic [31:0] d1;
        bit          g0, g1, own, rv0, rv1;
        logic [31:0] rd0;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
        idle_inputs();
        rstb = 1'b0;
        mem_clear = 1'b1;
        model_reset();
        @(posedge clk); #1;
        mem_clear = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;

        // Reset state
        mid();
        check("rst_owner", owner, 1);
        check("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        check("rst_rdata", {r0_rdata, r1_rdata}, 0);
        check("rst_idle_bus", {r0_gnt, r1_gnt, ram_en, ram_we, ram_addr, ram_din}, 0);
        tick();

        // rst | q0 k0 we0 a0 d0 | q1 k1 we1 a1 d1 | g0 g1 own rv0 rv1 rd0
        // Single requester: write then read back addr 5.
        tbl[0]  = '{1, 1,0,4'hF,11'd5,32'hDEADBEEF, 0,0,4'h0,11'd0,32'h0, 1,0,1,0,0,32'h0};
        tbl[1]  = '{0, 1,0,4'h0,11'd5,32'h0,        0,0,4'h0,11'd0,32'h0, 1,0,0,0,0,32'h0};
        tbl[2]  = '{0, 0,0,4'h0,11'd0,32'h0,        0,0,4'h0,11'd0,32'h0, 0,0,0,1,0,32'hDEADBEEF};
        tbl[3]  = '{0, 0,0,4'h0,11'd0,32'h0,        0,0,4'h0,11'd0,32'h0, 0,0,0,0,0,32'hDEADBEEF};
        // Contention without lock alternates, r0 first after reset.
        tbl[4]  = '{1, 1,0,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 1,0,1,0,0,32'h0};
        tbl[5]  = '{0, 1,0,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 0,1,0,1,0,32'hDEADBEEF};
        tbl[6]  = '{0, 1,0,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 1,0,1,0,1,32'hDEADBEEF};
        tbl[7]  = '{0, 1,0,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 0,1,0,1,0,32'hDEADBEEF};
        tbl[8]  = '{0, 0,0,4'h0,11'd0,32'h0,        0,0,4'h0,11'd0,32'h0, 0,0,1,0,1,32'hDEADBEEF};
        // r0 locks 3 cycles against r1, then drops req: r1 wins that cycle.
        tbl[9]  = '{1, 1,1,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 1,0,1,0,0,32'h0};
        tbl[10] = '{0, 1,1,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 1,0,0,1,0,32'hDEADBEEF};
        tbl[11] = '{0, 1,1,4'h0,11'd5,32'h0,        1,0,4'h0,11'd6,32'h0, 1,0,0,1,0,32'hDEADBEEF};
        tbl[12] = '{0, 0,0,4'h0,11'd0,32'h0,        1,0,4'h0,11'd6,32'h0, 0,1,0,1,0,32'hDEADBEEF};
        tbl[13] = '{0, 0,0,4'h0,11'd0,32'h0,        0,0,4'h0,11'd0,32'h0, 0,0,1,0,1,32'hDEADBEEF};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            r0_req = tbl[i].q0; r0_lock = tbl[i].k0; r0_we = tbl[i].we0;
            r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0;
            r1_req = tbl[i].q1; r1_lock = tbl[i].k1; r1_we = tbl[i].we1;
            r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
            mid();
            check($sformatf("vec%0d_gnt", i), {r0_gnt, r1_gnt}, {tbl[i].g0, tbl[i].g1});
            check($sformatf("vec%0d_owner", i), owner, tbl[i].own);
            check($sformatf("vec%0d_rvalid", i), {r0_rvalid, r1_rvalid}, {tbl[i].rv0, tbl[i].rv1});
            check($sformatf("vec%0d_r0_rdata", i), r0_rdata, tbl[i].rd0);
            tick();
        end

        // Burst lock: r1 locked vs r0. Cycle 1 is the reset tie (r0 wins),
        // then r1 holds 16 grants, r0 gets one forced slot, r1 resumes.
        do_reset();
        r0_req = 1; r0_addr = 11'd5;
        r1_req = 1; r1_lock = 1; r1_addr = 11'd6;
        for (int c = 1; c <= 20; c++) begin
            bit exp1;
            exp1 = (c >= 2 && c <= 17) || (c >= 19);
            mid();
            check($sformatf("burst_c%0d", c), {r0_gnt, r1_gnt}, {!exp1, exp1});
            check_all();
            tick();
        end

        // Reset between a granted r1 read and its return.
        do_reset();
        r1_req = 1; r1_addr = 11'd7;
        mid();
        check("rstrd_gnt", r1_gnt, 1);
        #1;
        rstb = 1'b0;
        r1_req = 0;
        #1;
        check("rstrd_now", {r1_rvalid, owner}, 2'b01);
        @(posedge clk); #1;
        check("rstrd_in_rst", r1_rvalid, 0);
        rstb = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            mid();
            check("rstrd_no_late", {r1_rvalid, owner}, 2'b01);
            tick();
        end

`ifdef QUADRAM_ARB_STATS_EN
        do_reset();
        r0_req = 1; r1_req = 1;
        for (int c = 0; c < 10; c++) begin
            mid();
            tick();
        end
        idle_inputs();
        mid();
        check("stats_10", {r0_stall_cnt, r1_stall_cnt}, {16'd5, 16'd5});
        tick();
`endif

        // Random traffic: phase 0 general mix, phase 1 long r1 locks with
        // sporadic r0 requests to hit forced rotation.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit ph = (c >= 300);
            r0_req   = ph ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) < 7);
            r0_lock  = $urandom_range(0, 3) != 0;
            r0_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r0_addr  = 11'($urandom_range(0, 15));
            r0_wdata = $urandom;
            r1_req   = ph ? 1'b1 : ($urandom_range(0, 9) < 7);
            r1_lock  = ph ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) != 0);
            r1_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r1_addr  = 11'($urandom_range(0, 15));
            r1_wdata = $urandom;
            mid();
            check_all();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
